// File: rtl/sram_ctrl_pkg.sv
// Shared definitions for the SRAM port arbiter.
// Holds the FSM state encoding, the default SRAM geometry and the requester IDs.
// The requester ID is also the encoding of the last-granted pointer.
package sram_ctrl_pkg;

  localparam int unsigned DEF_ADDR_W = 8;
  localparam int unsigned DEF_DATA_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACCESS  = 2'd1,
    ST_CAPTURE = 2'd2
  } state_e;

  localparam logic REQ_ID_A = 1'b0;
  localparam logic REQ_ID_B = 1'b1;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin pick, purely combinational.
// Ports:
//   req_a, req_b - request lines
//   last_gnt     - ID of the requester granted most recently
//   winner       - ID of the chosen requester (valid when any_req)
//   any_req      - at least one request pending
module rr_arbiter2
  import sram_ctrl_pkg::*;
(
  input  logic req_a,
  input  logic req_b,
  input  logic last_gnt,
  output logic winner,
  output logic any_req
);

  always_comb begin
    any_req = req_a | req_b;
    if (req_a && req_b) begin
      // On a tie the requester that did not win last time goes next.
      winner = ~last_gnt;
    end else if (req_b) begin
      winner = REQ_ID_B;
    end else begin
      winner = REQ_ID_A;
    end
  end

endmodule

// File: rtl/sram_port_arbiter.sv
// Two-requester round-robin controller for a single-port synchronous SRAM.
// Each command occupies the SRAM for one ACCESS cycle; reads add a CAPTURE
// cycle to bring DataOut back to the owning requester.
// Ports:
//   CLK, RST                         - clock, async active-high reset
//   REQ_x/WR_x/ADDR_x/WDATA_x        - requester command (x = A, B)
//   GNT_x                            - one-cycle accept pulse
//   RVALID_x/RDATA_x                 - read return, RDATA_x held until next read
//   SRAM_CS/WE/RD/ADDR/DIN, SRAM_DOUT - SRAM macro pins
//   BUSY                             - FSM not idle
module sram_port_arbiter
  import sram_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W  = DEF_ADDR_W,
  parameter int unsigned DATA_W  = DEF_DATA_W,
  parameter bit          RR_INIT = 1'b1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              REQ_A,
  input  logic              WR_A,
  input  logic [ADDR_W-1:0] ADDR_A,
  input  logic [DATA_W-1:0] WDATA_A,
  output logic              GNT_A,
  output logic              RVALID_A,
  output logic [DATA_W-1:0] RDATA_A,
  input  logic              REQ_B,
  input  logic              WR_B,
  input  logic [ADDR_W-1:0] ADDR_B,
  input  logic [DATA_W-1:0] WDATA_B,
  output logic              GNT_B,
  output logic              RVALID_B,
  output logic [DATA_W-1:0] RDATA_B,
  output logic              SRAM_CS,
  output logic              SRAM_WE,
  output logic              SRAM_RD,
  output logic [ADDR_W-1:0] SRAM_ADDR,
  output logic [DATA_W-1:0] SRAM_DIN,
  input  logic [DATA_W-1:0] SRAM_DOUT,
  output logic              BUSY
);

  state_e state;
  logic   last_gnt;
  logic   cur_id;  // owner of the command in flight
  logic   cur_wr;

  logic              winner;
  logic              any_req;
  logic              win_wr;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_wdata;

  rr_arbiter2 u_arb (
    .req_a    (REQ_A),
    .req_b    (REQ_B),
    .last_gnt (last_gnt),
    .winner   (winner),
    .any_req  (any_req)
  );

  always_comb begin
    win_wr    = WR_A;
    win_addr  = ADDR_A;
    win_wdata = WDATA_A;
    if (winner == REQ_ID_B) begin
      win_wr    = WR_B;
      win_addr  = ADDR_B;
      win_wdata = WDATA_B;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= ST_IDLE;
      last_gnt  <= RR_INIT;
      cur_id    <= REQ_ID_A;
      cur_wr    <= 1'b0;
      GNT_A     <= 1'b0;
      GNT_B     <= 1'b0;
      RVALID_A  <= 1'b0;
      RVALID_B  <= 1'b0;
      RDATA_A   <= '0;
      RDATA_B   <= '0;
      SRAM_CS   <= 1'b0;
      SRAM_WE   <= 1'b0;
      SRAM_RD   <= 1'b0;
      SRAM_ADDR <= '0;
      SRAM_DIN  <= '0;
    end else begin
      GNT_A    <= 1'b0;
      GNT_B    <= 1'b0;
      RVALID_A <= 1'b0;
      RVALID_B <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (any_req) begin
            SRAM_ADDR <= win_addr;
            SRAM_DIN  <= win_wdata;
            SRAM_CS   <= 1'b1;
            SRAM_WE   <= win_wr;
            SRAM_RD   <= ~win_wr;
            GNT_A     <= (winner == REQ_ID_A);
            GNT_B     <= (winner == REQ_ID_B);
            last_gnt  <= winner;
            cur_id    <= winner;
            cur_wr    <= win_wr;
            state     <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          // SRAM executes on this edge; address and data stay parked.
          SRAM_CS <= 1'b0;
          SRAM_WE <= 1'b0;
          SRAM_RD <= 1'b0;
          state   <= cur_wr ? ST_IDLE : ST_CAPTURE;
        end
        ST_CAPTURE: begin
          if (cur_id == REQ_ID_B) begin
            RDATA_B  <= SRAM_DOUT;
            RVALID_B <= 1'b1;
          end else begin
            RDATA_A  <= SRAM_DOUT;
            RVALID_A <= 1'b1;
          end
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign BUSY = (state != ST_IDLE);

endmodule
